// File: rtl/mac_product_accumulator.sv
// Accumulates a programmable-length run of multiplier products into a wide signed sum
// and presents it on a valid/ready port. Optional feature macro: ACC_SATURATE_EN (clamp instead of wrap).
module mac_product_accumulator #(
    parameter int P_WIDTH   = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 p_valid,
    input  logic [P_WIDTH-1:0]   p_data,
    input  logic                 p_signed,
    output logic                 p_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 busy,
    output logic                 overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [1:0]           state;
    logic [LEN_WIDTH-1:0] count;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;

    logic [ACC_WIDTH-1:0] operand;
    logic [ACC_WIDTH:0]   sum;
    logic                 sum_ovf;
    logic [ACC_WIDTH-1:0] next_acc;
    logic                 beat;

    always_comb begin
        operand = '0;
        if (p_signed) begin
            operand = {{(ACC_WIDTH-P_WIDTH){p_data[P_WIDTH-1]}}, p_data};
        end else begin
            operand = {{(ACC_WIDTH-P_WIDTH){1'b0}}, p_data};
        end
    end

    // One guard bit above the accumulator exposes signed overflow as a top-two-bit mismatch.
    always_comb begin
        sum     = {acc[ACC_WIDTH-1], acc} + {operand[ACC_WIDTH-1], operand};
        sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    end

`ifdef ACC_SATURATE_EN
    always_comb begin
        next_acc = sum[ACC_WIDTH-1:0];
        if (sum_ovf) begin
            next_acc = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        next_acc = sum[ACC_WIDTH-1:0];
    end
`endif

    assign beat = p_valid && (state == S_ACC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= len;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= (len == LEN_ZERO) ? S_HOLD : S_ACC;
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        acc   <= next_acc;
                        count <= count - LEN_ONE;
                        if (sum_ovf) begin
                            ovf <= 1'b1;
                        end
                        if (count == LEN_ONE) begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign p_ready   = (state == S_ACC);
    assign out_valid = (state == S_HOLD);
    assign busy      = (state == S_ACC) || (state == S_HOLD);
    assign acc_out   = acc;
    assign overflow  = ovf;

endmodule

// File: tb/tb_mac_product_accumulator.sv
// Directed self-checking bench for mac_product_accumulator: a default 32-bit instance plus a
// 17-bit instance used for overflow cases; expectations follow ACC_SATURATE_EN when defined.
module tb_mac_product_accumulator;

    logic        clk = 1'b0;
    logic        reset;

    logic        start;
    logic [7:0]  len;
    logic        p_valid;
    logic [15:0] p_data;
    logic        p_signed;
    logic        p_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] acc_out;
    logic        busy;
    logic        overflow;

    logic        o_start;
    logic [7:0]  o_len;
    logic        o_p_valid;
    logic [15:0] o_p_data;
    logic        o_p_signed;
    logic        o_p_ready;
    logic        o_out_valid;
    logic        o_out_ready;
    logic [16:0] o_acc_out;
    logic        o_busy;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;

`ifdef ACC_SATURATE_EN
    localparam logic [16:0] EXP_OVF_SUM = 17'h0FFFF;
`else
    localparam logic [16:0] EXP_OVF_SUM = 17'h17FFD;
`endif

    always #5 clk = ~clk;

    mac_product_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .p_valid   (p_valid),
        .p_data    (p_data),
        .p_signed  (p_signed),
        .p_ready   (p_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    mac_product_accumulator #(.P_WIDTH(16), .ACC_WIDTH(17), .LEN_WIDTH(8)) dut17 (
        .clk       (clk),
        .reset     (reset),
        .start     (o_start),
        .len       (o_len),
        .p_valid   (o_p_valid),
        .p_data    (o_p_data),
        .p_signed  (o_p_signed),
        .p_ready   (o_p_ready),
        .out_valid (o_out_valid),
        .out_ready (o_out_ready),
        .acc_out   (o_acc_out),
        .busy      (o_busy),
        .overflow  (o_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (p_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_p_ready got %b expected 0", p_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (acc_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_acc_out got %h expected 0", acc_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b expected 0", overflow); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b expected 0", busy); end
    endtask

    task automatic test_signed_run();
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        checks++; if (p_ready !== 1'b1) begin errors++; $display("[TB] FAIL signed_p_ready got %b expected 1", p_ready); end
        p_valid = 1'b1; p_signed = 1'b1; p_data = 16'd100;
        tick();
        p_data = 16'hFFCE;
        tick();
        p_data = 16'h7F01;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL signed_early_valid got %b expected 0", out_valid); end
        p_data = 16'hC000;
        tick();
        p_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL signed_out_valid got %b expected 1", out_valid); end
        checks++; if (acc_out !== 32'd16179) begin errors++; $display("[TB] FAIL signed_acc_out got %0d expected 16179", $signed(acc_out)); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL signed_overflow got %b expected 0", overflow); end
        checks++; if (p_ready !== 1'b0) begin errors++; $display("[TB] FAIL signed_hold_p_ready got %b expected 0", p_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL signed_after_handshake got %b expected 0", out_valid); end
    endtask

    task automatic test_unsigned_gaps();
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p_valid = 1'b1; p_signed = 1'b0; p_data = 16'hFFFF;
            tick();
            p_valid = 1'b0;
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    checks++; if (p_ready !== 1'b1) begin errors++; $display("[TB] FAIL gap_p_ready got %b expected 1", p_ready); end
                    tick();
                end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL gap_out_valid got %b expected 1", out_valid); end
        checks++; if (acc_out !== 32'd196605) begin errors++; $display("[TB] FAIL gap_acc_out got %0d expected 196605", acc_out); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_out_valid got %b expected 1", out_valid); end
        checks++; if (acc_out !== 32'd0) begin errors++; $display("[TB] FAIL zero_acc_out got %h expected 0", acc_out); end
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 8'd5;
            tick();
            start = 1'b0;
            checks++; if (out_valid !== 1'b1 || acc_out !== 32'd0) begin errors++; $display("[TB] FAIL zero_hold got valid %b acc %h expected 1 / 0", out_valid, acc_out); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (busy !== 1'b0 || p_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_no_queue got busy %b p_ready %b expected 0 / 0", busy, p_ready); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_still_idle got %b expected 0", busy); end
    endtask

    task automatic test_overflow();
        o_start = 1'b1; o_len = 8'd3;
        tick();
        o_start = 1'b0;
        o_p_valid = 1'b1; o_p_signed = 1'b1; o_p_data = 16'h7FFF;
        tick();
        tick();
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early got %b expected 0", o_overflow); end
        tick();
        o_p_valid = 1'b0;
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b expected 1", o_overflow); end
        checks++; if (o_acc_out !== EXP_OVF_SUM) begin errors++; $display("[TB] FAIL ovf_acc_out got %h expected %h", o_acc_out, EXP_OVF_SUM); end
        o_out_ready = 1'b1;
        tick();
        o_out_ready = 1'b0;
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b expected 1", o_overflow); end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        p_valid = 1'b1; p_signed = 1'b1; p_data = 16'd3;
        tick();
        p_data = 16'd4;
        tick();
        p_valid = 1'b0;
        checks++; if (acc_out !== 32'd7) begin errors++; $display("[TB] FAIL midrun_partial got %0d expected 7", acc_out); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || p_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrun_ctrl got busy %b p_ready %b out_valid %b expected 0", busy, p_ready, out_valid); end
        checks++; if (acc_out !== 32'd0 || overflow !== 1'b0 || o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL midrun_data got acc %h ovf %b ovf17 %b expected 0", acc_out, overflow, o_overflow); end
        tick();
        reset = 1'b1;
        tick();
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        p_valid = 1'b1; p_data = 16'd7;
        tick();
        p_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || acc_out !== 32'd7) begin errors++; $display("[TB] FAIL midrun_rerun got valid %b acc %0d expected 1 / 7", out_valid, acc_out); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        o_start = 1'b1; o_len = 8'd3; o_out_ready = 1'b1;
        tick();
        o_p_valid = 1'b1; o_p_signed = 1'b1; o_p_data = 16'h7FFF;
        tick();
        tick();
        tick();
        o_p_valid = 1'b0; o_len = 8'd1;
        checks++; if (o_out_valid !== 1'b1 || o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first got valid %b ovf %b expected 1 / 1", o_out_valid, o_overflow); end
        tick();
        checks++; if (o_busy !== 1'b0 || o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle got busy %b ovf %b expected 0 / 1", o_busy, o_overflow); end
        tick();
        o_start = 1'b0;
        checks++; if (o_p_ready !== 1'b1 || o_overflow !== 1'b0 || o_acc_out !== 17'd0) begin errors++; $display("[TB] FAIL b2b_second got p_ready %b ovf %b acc %h expected 1 / 0 / 0", o_p_ready, o_overflow, o_acc_out); end
        o_p_valid = 1'b1; o_p_data = 16'd5;
        tick();
        o_p_valid = 1'b0;
        checks++; if (o_out_valid !== 1'b1 || o_acc_out !== 17'd5) begin errors++; $display("[TB] FAIL b2b_result got valid %b acc %h expected 1 / 5", o_out_valid, o_acc_out); end
        tick();
        o_out_ready = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done got %b expected 0", o_busy); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0; len = 8'd0; p_valid = 1'b0; p_data = 16'd0; p_signed = 1'b0; out_ready = 1'b0;
        o_start = 1'b0; o_len = 8'd0; o_p_valid = 1'b0; o_p_data = 16'd0; o_p_signed = 1'b0; o_out_ready = 1'b0;
        test_reset();
        test_signed_run();
        test_unsigned_gaps();
        test_len_zero();
        test_overflow();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_product_accumulator.md
# mac_product_accumulator

Downstream stage for the registered 8x8 multiplier: consumes its 16-bit product stream one product per cycle and accumulates a programmable-length run of products (a dot product) into a wide signed accumulator. Presents the final sum on a valid/ready output port with backpressure. Sits between the multiplier output register and the block's result/write-back logic.

## Interface
- P_WIDTH, 16, product width; equals multiplier A_chop_size+B_chop_size
- ACC_WIDTH, 32, accumulator and result width; must be > P_WIDTH
- LEN_WIDTH, 8, width of the run-length input
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately
- start  in  1  request a new run; accepted only in IDLE
- len  in  LEN_WIDTH  number of products in the run; sampled when start is accepted
- p_valid  in  1  product beat valid
- p_data  in  P_WIDTH  product from multiplier C output
- p_signed  in  1  1: p_data is two's complement (A_sign|B_sign of that product); 0: unsigned
- p_ready  out  1  accumulator accepts a beat this cycle
- out_valid  out  1  acc_out holds a finished run
- out_ready  in  1  consumer takes the result
- acc_out  out  ACC_WIDTH  finished accumulation, signed
- busy  out  1  high in ACC or HOLD
- overflow  out  1  sticky: signed overflow occurred during the current or last run

## Operation
- States: IDLE, ACC, HOLD. Reset state IDLE.
- IDLE: p_ready=0, out_valid=0. start=1 → latch len into count, clear acc and overflow; len≠0 → ACC, len=0 → HOLD with acc=0.
- ACC: p_ready=1. Each beat (p_valid&p_ready): operand = sign-extend p_data if p_signed else zero-extend, to ACC_WIDTH; acc ← acc+operand; count ← count−1. Beat with count==1 → HOLD. Cycles with p_valid=0 leave acc/count unchanged.
- HOLD: p_ready=0, out_valid=1, acc_out=acc stable. out_ready=1 → IDLE. Result is held indefinitely otherwise.
- start outside IDLE is ignored (not queued). len changes outside the accepting cycle have no effect.
- Overflow: sum computed at ACC_WIDTH+1 bits; signed overflow when top two bits of the extended sum differ. Sets overflow; cleared only by accepted start or reset.
- acc_out is driven from the acc register in all states; only meaningful while out_valid=1.
- Reset values: p_ready=0, out_valid=0, acc_out=0, busy=0, overflow=0.
- Reset asserted mid-run: run discarded, IDLE, all outputs to reset values; no result emitted.

## Timing
- start accepted at edge t → ACC from t+1; p_ready=1 in cycle t+1.
- Full throughput: one product per cycle, no bubbles required.
- Last beat accepted at edge k → out_valid=1 in cycle k+1 with final sum (latency 1 from last beat).
- len=0: out_valid=1 in cycle t+1, acc_out=0.
- Output handshake at edge h → IDLE at h+1; earliest next start acceptance at edge h+1, so back-to-back runs cost one idle cycle.
- overflow updates on the same edge as the offending accumulation.

## Configuration
- ACC_SATURATE_EN defined: on overflow acc clamps to 2^(ACC_WIDTH−1)−1 (positive) or −2^(ACC_WIDTH−1) (negative); later beats add to the clamped value; overflow still set.
- Not defined: acc wraps modulo 2^ACC_WIDTH; overflow flag still set.

## Test plan
- len=4, signed products 100, −50, 0x7F01 (32513), −16384 → out_valid one cycle after 4th beat, acc_out=16179, overflow=0.
- len=3, unsigned p_data=0xFFFF ×3 with p_valid gaps of 2 cycles → acc_out=196605 (0x2FFFD); p_ready stays 1 through gaps.
- len=0 start → out_valid next cycle, acc_out=0; hold out_ready=0 for 5 cycles → acc_out and out_valid stable; start pulses during HOLD ignored.
- ACC_WIDTH=17, signed 0x7FFF ×3 → overflow=1; without macro acc_out=0x17FFD as 17-bit wrap (−32771 sign-interpreted), with ACC_SATURATE_EN acc_out=0x0FFFF (65535).
- Assert reset low mid-run after 2 of 5 beats → all outputs 0 asynchronously; after release, new len=1 run with 7 → acc_out=7.
- Back-to-back runs: out_ready=1 and start=1 held → second run accepted exactly one cycle after first result handshake; overflow from first run cleared.
